// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte plus strobe and error qualifiers out.
interface uart_rx_if;
    logic       dataIn;
    logic [7:0] dataOut;
    logic       valid;
    logic       frameError;
    logic       parityError;

    modport master (output dataIn, input dataOut, valid, frameError, parityError);
    modport slave  (input dataIn, output dataOut, valid, frameError, parityError);
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB-first, optional parity, 1 or 2 stop bits, mid-bit sampling.
// Define UART_RX_MAJORITY_EN to take each sample as a 2-of-3 vote over the last three rxS values.
module uart_rx #(
    parameter int unsigned PRESCALER_COUNT = 234,
    parameter logic [1:0]  PARITY          = 2'b00,
    parameter logic        STOP_BITS       = 1'b0
) (
    input logic      clk,
    input logic      rst_n,
    uart_rx_if.slave bus
);
    // state    | meaning
    // S_IDLE   | waiting for a high->low edge on rxS
    // S_START  | half-bit wait, then confirm start bit is still low
    // S_DATA   | sampling 8 data bits, LSB first
    // S_PARITY | sampling the parity bit
    // S_STOP   | sampling 1 or 2 stop bits, then delivering the byte
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam int unsigned   CW      = $clog2(PRESCALER_COUNT);
    localparam int unsigned   HALF    = PRESCALER_COUNT / 2;
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(PRESCALER_COUNT - 1);
    localparam logic          PAR_EN  = (PARITY == 2'b01) || (PARITY == 2'b10);
    localparam logic          PAR_ODD = (PARITY == 2'b01);

    logic rx_meta_q, rx_s_q, rx_prev_q;
    logic rx_samp;

`ifdef UART_RX_MAJORITY_EN
    logic rx_prev2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_prev2_q <= 1'b1;
        else        rx_prev2_q <= rx_prev_q;
    end

    assign rx_samp = (rx_prev2_q & rx_prev_q) | (rx_prev_q & rx_s_q) | (rx_prev2_q & rx_s_q);
`else
    assign rx_samp = rx_s_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.dataIn;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_idx_q;
    logic            stop_idx_q;
    logic [7:0]      shift_q;
    logic            frame_err_q, par_err_q;
    logic [7:0]      data_out_q;
    logic            valid_q, frame_error_q, parity_error_q;

    logic [7:0]      shift_d;
    logic            frame_err_d;
    logic            par_err_d;

    assign shift_d     = {rx_samp, shift_q[7:1]};
    assign frame_err_d = frame_err_q | ~rx_samp;
    assign par_err_d   = rx_samp ^ (^shift_q) ^ PAR_ODD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            bit_idx_q      <= '0;
            stop_idx_q     <= 1'b0;
            shift_q        <= '0;
            frame_err_q    <= 1'b0;
            par_err_q      <= 1'b0;
            data_out_q     <= '0;
            valid_q        <= 1'b0;
            frame_error_q  <= 1'b0;
            parity_error_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            cnt_q   <= cnt_q + CW'(1);
            case (state_q)
                S_IDLE: begin
                    cnt_q <= '0;
                    if (!rx_s_q && rx_prev_q) state_q <= S_START;
                end
                S_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q       <= '0;
                        bit_idx_q   <= '0;
                        stop_idx_q  <= 1'b0;
                        frame_err_q <= 1'b0;
                        par_err_q   <= 1'b0;
                        state_q     <= rx_samp ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q     <= '0;
                        shift_q   <= shift_d;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_q <= PAR_EN ? S_PARITY : S_STOP;
                    end
                end
                S_PARITY: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q     <= '0;
                        par_err_q <= par_err_d;
                        state_q   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (cnt_q == BIT_M1) begin
                        cnt_q <= '0;
                        if (STOP_BITS && !stop_idx_q) begin
                            frame_err_q <= frame_err_d;
                            stop_idx_q  <= 1'b1;
                        end else begin
                            // Back to IDLE in the delivery cycle so a start bit right after the stop bit is caught.
                            data_out_q     <= shift_q;
                            frame_error_q  <= frame_err_d;
                            parity_error_q <= par_err_q;
                            valid_q        <= 1'b1;
                            state_q        <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.dataOut     = data_out_q;
    assign bus.valid       = valid_q;
    assign bus.frameError  = frame_error_q;
    assign bus.parityError = parity_error_q;
endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver; the downstream counterpart of the transmitter on the board link. Takes the asynchronous serial line from the pin, synchronises it, detects and validates a start bit, samples 8 data bits LSB-first at mid-bit, and checks optional parity and 1 or 2 stop bits. It presents each received byte with a one-cycle valid strobe and error qualifiers. Its frame format parameters match the transmitter's.

## Interface
- PRESCALER_COUNT, 234: clk cycles per bit (27 MHz / 115200); must be ≥ 4.
- PARITY, 2'b00: 2'b00 none, 2'b01 odd, 2'b10 even; 2'b11 treated as none.
- STOP_BITS, 1'b0: 1'b0 one stop bit, 1'b1 two stop bits.

- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- dataIn  in  1  serial line from the pin, idle high, asynchronous to clk.
- dataOut  out  8  last received byte; held until the next frame completes.
- valid  out  1  one-cycle pulse when dataOut and the error flags update.
- frameError  out  1  a stop bit sampled low in the frame just delivered.
- parityError  out  1  parity mismatch in the frame just delivered; 0 when PARITY is none.

## Operation
- Input path: 2-flop synchroniser on dataIn, reset to 1. The state machine uses only the synchronised value `rxS`.
- Bit counter: width $clog2(PRESCALER_COUNT). HALF = PRESCALER_COUNT/2, rounded down.
- States:
  - IDLE → START on the first cycle with rxS==0 whose previous rxS was 1 (falling edge). Counter cleared.
  - START: at count HALF−1, sample rxS. If 0 → DATA; if 1 → IDLE (glitch, no output).
  - DATA: every PRESCALER_COUNT cycles, sample into a shift register, LSB first. After the 8th sample → PARITY if parity is enabled, else → STOP.
  - PARITY: one sample; compare against the XOR of the data, inverted for odd parity.
  - STOP: 1 or 2 samples. Any low sample sets the frame-error flag.
- After the last stop sample: dataOut ← shift register, frameError and parityError ← frame flags, valid=1 for one cycle, → IDLE.
- Break or stuck-low line: IDLE requires a high→low edge, so no new frame starts until rxS returns high.
- Reset mid-frame: state → IDLE, counter and shift register cleared, frame discarded.

## Timing
- Reset values: dataOut=8'h00, valid=0, frameError=0, parityError=0, state IDLE, synchroniser=1.
- Pin-to-detection: edge detection happens 2–3 clk after the pin transition (synchroniser).
- Sample points: let T0 be the detection cycle.
  - Start sample at T0+HALF.
  - Sample k (k=1..N) at T0+HALF+k·PRESCALER_COUNT, where N = 8 + (parity?1:0) + (STOP_BITS?2:1).
- Delivery: valid is high in cycle T0+HALF+N·PRESCALER_COUNT+1.
- Re-arm: IDLE is re-entered in the same cycle valid is high, so back-to-back frames with no idle gap are accepted.
- Outputs are registered; there is no backpressure. A consumer must capture dataOut on valid.

## Configuration
- UART_RX_MAJORITY_EN:
  - Defined: each sample (start, data, parity, stop) is the 2-of-3 majority of rxS in cycles t−2, t−1 and t at the sample point. Latency is unchanged.
  - Undefined: each sample is the single rxS value at the sample point.

## Test plan
All scenarios use PRESCALER_COUNT=16 (HALF=8).
- 0x55, no parity, 1 stop → one valid pulse at T0+8+9·16+1=T0+153; dataOut=0x55, frameError=0, parityError=0.
- PARITY=2'b10, send 0xA5:
  - Parity bit 0 → dataOut=0xA5, parityError=0.
  - Parity bit 1 → parityError=1, valid still pulses.
- 0x3C with stop bit driven low, line then held low 100 cycles → valid with frameError=1, no further valid; line high for 16 cycles then frame 0x12 → dataOut=0x12, frameError=0.
- 3-cycle low glitch on an idle line → no valid, state IDLE; following frame 0x7E received correctly.
- rst_n pulsed low during data bit 4 of a frame → all outputs 0 immediately; next frame 0x81 received correctly.
- STOP_BITS=1, 0x00 and 0xFF back-to-back → two valid pulses 11·16 cycles apart with the correct data. With UART_RX_MAJORITY_EN, a 1-cycle inverted glitch at a data sample point → byte still correct.
